// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: in-order pipeline writeback vs. buffered
// MDU results. The buffer drains into idle slots. A starvation limit or a full
// buffer forces the buffer head to win, which stalls the pipeline for that cycle.
module wb_arbiter #(
   parameter int XLEN     = 32,
   parameter int REGW     = 5,
   parameter int DEPTH    = 2,
   parameter int MAX_WAIT = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   pipe_valid_i,
   input  logic                   pipe_we_i,
   input  logic [REGW-1:0]        pipe_rd_i,
   input  logic [XLEN-1:0]        pipe_data_i,
   input  logic                   mdu_valid_i,
   input  logic [REGW-1:0]        mdu_rd_i,
   input  logic [XLEN-1:0]        mdu_data_i,
   output logic                   mdu_ready_o,
   output logic                   stall_o,
   output logic                   rf_we_o,
   output logic [REGW-1:0]        rf_waddr_o,
   output logic [XLEN-1:0]        rf_wdata_o,
   output logic [(1<<REGW)-1:0]   busy_mask_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = $clog2(MAX_WAIT + 1);

   // circular buffer storage plus a per-slot valid bit for the busy mask
   logic [REGW-1:0]  rd_q   [DEPTH];
   logic [XLEN-1:0]  data_q [DEPTH];
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic [SW-1:0]    starve_q, starve_d;

   logic             rf_we_q, rf_we_d;
   logic [REGW-1:0]  rf_waddr_q, rf_waddr_d;
   logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;

   logic pipe_cand, buf_cand, buf_win, push, pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // arbitration decision; ready looks at registered count only (no pass-through)
   always_comb begin
      pipe_cand   = pipe_valid_i && pipe_we_i && (pipe_rd_i != '0);
      buf_cand    = (count_q != '0);
      buf_win     = buf_cand && (!pipe_cand || (starve_q == SW'(MAX_WAIT)) ||
                                 (count_q == CW'(DEPTH)));
      stall_o     = pipe_cand && buf_win;
      mdu_ready_o = (count_q < CW'(DEPTH));
      pop         = buf_win;
      // rd=0 completes the handshake but stores nothing
      push        = mdu_valid_i && mdu_ready_o && (mdu_rd_i != '0);
   end

   // buffer pointers, occupancy, starvation counter and write-port next state
   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      vld_d      = vld_q;
      count_d    = count_q;
      starve_d   = starve_q;
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (pop) begin
         head_d        = nxt(head_q);
         vld_d[head_q] = 1'b0;
      end
      if (push) begin
         tail_d        = nxt(tail_q);
         vld_d[tail_q] = 1'b1;
      end
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
      // a non-empty buffer that did not pop has lost this cycle
      if (pop || !buf_cand)                   starve_d = '0;
      else if (starve_q != SW'(MAX_WAIT))     starve_d = starve_q + 1'b1;
      if (buf_win) begin
         rf_we_d    = 1'b1;
         rf_waddr_d = rd_q[head_q];
         rf_wdata_d = data_q[head_q];
      end else if (pipe_cand) begin
         rf_we_d    = 1'b1;
         rf_waddr_d = pipe_rd_i;
         rf_wdata_d = pipe_data_i;
      end
   end

   // control state and registered write port
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q     <= '0;
         tail_q     <= '0;
         vld_q      <= '0;
         count_q    <= '0;
         starve_q   <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         vld_q      <= vld_d;
         count_q    <= count_d;
         starve_q   <= starve_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   // payload storage; validity lives in vld_q, so no reset is needed here
   always_ff @(posedge clk_i) begin
      if (push) begin
         rd_q[tail_q]   <= mdu_rd_i;
         data_q[tail_q] <= mdu_data_i;
      end
   end

   // one-hot OR of destinations currently held in the buffer
   always_comb begin
      busy_mask_o = '0;
      for (int i = 0; i < DEPTH; i++)
         if (vld_q[i]) busy_mask_o[rd_q[i]] = 1'b1;
   end

   assign rf_we_o    = rf_we_q;
   assign rf_waddr_o = rf_waddr_q;
   assign rf_wdata_o = rf_wdata_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the arbitration rules.
module tb_wb_arbiter;

   localparam int DEPTH    = 2;
   localparam int MAX_WAIT = 4;

   logic        clk, rst_n;
   logic        pipe_valid, pipe_we, mdu_valid;
   logic [4:0]  pipe_rd, mdu_rd;
   logic [31:0] pipe_data, mdu_data;
   logic        mdu_ready, stall, rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata, busy_mask;

   int n_tests = 0;
   int n_fail  = 0;

   wb_arbiter #(.XLEN(32), .REGW(5), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .pipe_valid_i(pipe_valid), .pipe_we_i(pipe_we), .pipe_rd_i(pipe_rd), .pipe_data_i(pipe_data),
      .mdu_valid_i(mdu_valid), .mdu_rd_i(mdu_rd), .mdu_data_i(mdu_data),
      .mdu_ready_o(mdu_ready), .stall_o(stall),
      .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
      .busy_mask_o(busy_mask)
   );

   always #5 clk = ~clk;

   // reference model: FIFO as a queue, starvation as a plain integer
   typedef struct packed { logic [4:0] rd; logic [31:0] data; } ent_t;
   ent_t        mq[$];
   int          m_starve;
   logic        m_we, m_bwin, e_stall, e_ready;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata, e_busy;

   task automatic model_reset();
      mq.delete();
      m_starve = 0; m_we = 0; m_waddr = 0; m_wdata = 0;
   endtask

   task automatic model_comb();
      bit pc;
      pc      = pipe_valid && pipe_we && (pipe_rd != 0);
      m_bwin  = (mq.size() > 0) && (!pc || m_starve == MAX_WAIT || mq.size() == DEPTH);
      e_stall = pc && m_bwin;
      e_ready = (mq.size() < DEPTH);
      e_busy  = 0;
      foreach (mq[i]) e_busy[mq[i].rd] = 1'b1;
   endtask

   task automatic model_edge();
      bit pc, rdy;
      model_comb();
      pc  = pipe_valid && pipe_we && (pipe_rd != 0);
      rdy = e_ready;
      if (m_bwin) begin
         m_we = 1; m_waddr = mq[0].rd; m_wdata = mq[0].data;
         mq.delete(0);
         m_starve = 0;
      end else begin
         if (pc) begin m_we = 1; m_waddr = pipe_rd; m_wdata = pipe_data; end
         else m_we = 0;
         if (mq.size() == 0) m_starve = 0;
         else if (m_starve < MAX_WAIT) m_starve++;
      end
      if (mdu_valid && rdy && mdu_rd != 0) mq.push_back({mdu_rd, mdu_data});
   endtask

   // called at a falling edge: advance the model and the DUT by one edge
   task automatic step();
      model_edge();
      @(posedge clk); #1;
   endtask

   task automatic drive(input bit pv, input bit pw, input logic [4:0] prd, input logic [31:0] pd,
                        input bit mv, input logic [4:0] mrd, input logic [31:0] md);
      pipe_valid = pv; pipe_we = pw; pipe_rd = prd; pipe_data = pd;
      mdu_valid = mv; mdu_rd = mrd; mdu_data = md;
   endtask

   task automatic test_reset();
      rst_n = 0;
      drive(0, 0, 0, 0, 0, 0, 0);
      model_reset();
      #2;
      n_tests++;
      if ({rf_we, rf_waddr, rf_wdata, stall, mdu_ready, busy_mask} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 32'd0}) begin
         n_fail++;
         $display("FAIL reset_state: we=%b addr=%0d data=%h stall=%b rdy=%b busy=%h, want 0/0/0/0/1/0",
                  rf_we, rf_waddr, rf_wdata, stall, mdu_ready, busy_mask);
      end
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1;
      model_comb();
      step();
   endtask

   task automatic test_pipe_write();
      drive(1, 1, 5, 32'h0000_1234, 0, 0, 0);
      @(negedge clk); model_comb();
      n_tests++;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL pipe_stall: got %b want 0", stall); end
      step();
      n_tests++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h0000_1234}) begin
         n_fail++; $display("FAIL pipe_write: got we=%b %0d/%h want 1 5/00001234", rf_we, rf_waddr, rf_wdata);
      end
      drive(1, 1, 0, 32'h5555_5555, 0, 0, 0);
      @(negedge clk); model_comb();
      n_tests++;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL pipe_rd0_stall: got %b want 0", stall); end
      step();
      n_tests++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd5, 32'h0000_1234}) begin
         n_fail++; $display("FAIL pipe_rd0_nowrite: got we=%b %0d/%h want 0 5/00001234", rf_we, rf_waddr, rf_wdata);
      end
      drive(1, 0, 6, 32'h6666_6666, 0, 0, 0);
      @(negedge clk); step();
      n_tests++;
      if (rf_we !== 1'b0) begin n_fail++; $display("FAIL pipe_we0_nowrite: got we=%b want 0", rf_we); end
      drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_mdu_write();
      drive(0, 0, 0, 0, 1, 7, 32'hDEAD_BEEF);
      @(negedge clk); model_comb();
      n_tests++;
      if (mdu_ready !== 1'b1) begin n_fail++; $display("FAIL mdu_ready_empty: got %b want 1", mdu_ready); end
      step();
      drive(0, 0, 0, 0, 0, 0, 0);
      n_tests++;
      if ({rf_we, busy_mask} !== {1'b0, 32'h0000_0080}) begin
         n_fail++; $display("FAIL mdu_busy_set: got we=%b busy=%h want 0 00000080", rf_we, busy_mask);
      end
      @(negedge clk); model_comb();
      step();
      n_tests++;
      if ({rf_we, rf_waddr, rf_wdata, busy_mask} !== {1'b1, 5'd7, 32'hDEAD_BEEF, 32'd0}) begin
         n_fail++; $display("FAIL mdu_write: got we=%b %0d/%h busy=%h want 1 7/deadbeef 0",
                            rf_we, rf_waddr, rf_wdata, busy_mask);
      end
   endtask

   task automatic test_starvation();
      drive(1, 1, 1, 32'h101, 1, 9, 32'h9999_0009);
      @(negedge clk); model_comb(); step();
      n_tests++;
      if ({rf_we, rf_waddr} !== {1'b1, 5'd1}) begin n_fail++; $display("FAIL starve_first: got %b/%0d want 1/1", rf_we, rf_waddr); end
      for (int c = 2; c <= 5; c++) begin
         drive(1, 1, 5'(c), 32'h100 + c, 0, 0, 0);
         @(negedge clk); model_comb();
         n_tests++;
         if (stall !== 1'b0) begin n_fail++; $display("FAIL starve_lose_stall: cycle %0d got %b want 0", c, stall); end
         step();
         n_tests++;
         if ({rf_waddr, rf_wdata} !== {5'(c), 32'h100 + c}) begin
            n_fail++; $display("FAIL starve_lose_write: got %0d/%h want %0d/%h", rf_waddr, rf_wdata, c, 32'h100 + c);
         end
      end
      drive(1, 1, 6, 32'h106, 0, 0, 0);
      @(negedge clk); model_comb();
      n_tests++;
      if (stall !== 1'b1) begin n_fail++; $display("FAIL starve_force_stall: got %b want 1", stall); end
      step();
      n_tests++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'h9999_0009}) begin
         n_fail++; $display("FAIL starve_force_write: got %b %0d/%h want 1 9/99990009", rf_we, rf_waddr, rf_wdata);
      end
      @(negedge clk); model_comb();
      n_tests++;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL starve_after_stall: got %b want 0", stall); end
      step();
      n_tests++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd6, 32'h106}) begin
         n_fail++; $display("FAIL starve_held_write: got %b %0d/%h want 1 6/106", rf_we, rf_waddr, rf_wdata);
      end
      drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_full_buffer();
      int  prd;
      bit  seen20, seen21;
      drive(1, 1, 10, 32'h10A, 1, 20, 32'hA20);
      @(negedge clk); model_comb(); step();
      drive(1, 1, 11, 32'h10B, 1, 21, 32'hA21);
      @(negedge clk); model_comb();
      n_tests++;
      if ({stall, mdu_ready} !== 2'b01) begin n_fail++; $display("FAIL full_second_push: stall=%b rdy=%b want 0 1", stall, mdu_ready); end
      step();
      drive(1, 1, 12, 32'h10C, 0, 0, 0);
      n_tests++;
      if (mdu_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", mdu_ready); end
      @(negedge clk); model_comb();
      n_tests++;
      if (stall !== 1'b1) begin n_fail++; $display("FAIL full_stall: got %b want 1", stall); end
      step();
      n_tests++;
      if ({rf_we, rf_waddr, mdu_ready} !== {1'b1, 5'd20, 1'b1}) begin
         n_fail++; $display("FAIL full_drain_first: we=%b addr=%0d rdy=%b want 1 20 1", rf_we, rf_waddr, mdu_ready);
      end
      seen20 = 1; seen21 = 0; prd = 13;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk); model_comb();
         n_tests++;
         if (stall !== e_stall) begin n_fail++; $display("FAIL full_stall_seq: k=%0d got %b want %b", k, stall, e_stall); end
         step();
         if (rf_we && rf_waddr == 5'd21) seen21 = seen20;
         if (!e_stall) begin drive(1, 1, 5'(prd), 32'h100 + prd, 0, 0, 0); prd++; end
      end
      n_tests++;
      if (seen21 !== 1'b1 || busy_mask !== 32'd0) begin
         n_fail++; $display("FAIL full_order: second entry written=%b busy=%h want 1 0", seen21, busy_mask);
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk); model_comb(); step();
   endtask

   task automatic test_rd0();
      drive(1, 1, 1, 32'h201, 1, 3, 32'h303);
      @(negedge clk); model_comb(); step();
      drive(1, 1, 2, 32'h202, 1, 0, 32'h404);
      @(negedge clk); model_comb();
      n_tests++;
      if (mdu_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_handshake: rdy=%b want 1", mdu_ready); end
      step();
      n_tests++;
      if ({rf_waddr, mdu_ready, busy_mask} !== {5'd2, 1'b1, 32'h0000_0008}) begin
         n_fail++; $display("FAIL rd0_not_stored: addr=%0d rdy=%b busy=%h want 2 1 00000008", rf_waddr, mdu_ready, busy_mask);
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk); model_comb(); step();
      n_tests++;
      if ({rf_we, rf_waddr, rf_wdata, busy_mask} !== {1'b1, 5'd3, 32'h303, 32'd0}) begin
         n_fail++; $display("FAIL rd0_drain: got %b %0d/%h busy=%h want 1 3/303 0", rf_we, rf_waddr, rf_wdata, busy_mask);
      end
      @(negedge clk); model_comb(); step();
      n_tests++;
      if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rd0_no_extra_write: we=%b want 0", rf_we); end
   endtask

   task automatic test_reset_mid();
      int wrote;
      drive(1, 1, 1, 32'h301, 1, 14, 32'hE14);
      @(negedge clk); model_comb(); step();
      drive(1, 1, 2, 32'h302, 1, 15, 32'hE15);
      @(negedge clk); model_comb(); step();
      n_tests++;
      if (busy_mask !== 32'h0000_C000) begin n_fail++; $display("FAIL rstmid_filled: busy=%h want 0000c000", busy_mask); end
      drive(1, 1, 3, 32'h303, 0, 0, 0);
      #2 rst_n = 0;
      #1;
      model_reset();
      n_tests++;
      if ({rf_we, busy_mask, mdu_ready, stall} !== {1'b0, 32'd0, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL rstmid_async: we=%b busy=%h rdy=%b stall=%b want 0 0 1 0", rf_we, busy_mask, mdu_ready, stall);
      end
      @(posedge clk);
      @(negedge clk); rst_n = 1;
      drive(0, 0, 0, 0, 0, 0, 0);
      model_comb(); step();
      wrote = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk); model_comb(); step();
         if (rf_we !== 1'b0) wrote++;
      end
      n_tests++;
      if (wrote != 0) begin n_fail++; $display("FAIL rstmid_no_stale_write: %0d writes after reset want 0", wrote); end
   endtask

   task automatic test_random();
      bit hold = 0;
      for (int i = 0; i < 400; i++) begin
         if (!hold) begin
            pipe_valid = ($urandom_range(0, 9) < 7);
            pipe_we    = ($urandom_range(0, 7) != 0);
            pipe_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            pipe_data  = $urandom;
         end
         mdu_valid = ($urandom_range(0, 9) < 4);
         mdu_rd    = 5'($urandom_range(0, 7));
         mdu_data  = $urandom;
         @(negedge clk); model_comb();
         n_tests++;
         if ({stall, mdu_ready, busy_mask} !== {e_stall, e_ready, e_busy}) begin
            n_fail++; $display("FAIL rand_comb: cyc %0d stall=%b rdy=%b busy=%h want %b %b %h",
                               i, stall, mdu_ready, busy_mask, e_stall, e_ready, e_busy);
         end
         hold = e_stall;
         step();
         n_tests++;
         if ({rf_we, rf_waddr, rf_wdata} !== {m_we, m_waddr, m_wdata}) begin
            n_fail++; $display("FAIL rand_write: cyc %0d got %b %0d/%h want %b %0d/%h",
                               i, rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata);
         end
      end
      drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      clk = 0;
      test_reset();
      test_pipe_write();
      test_mdu_write();
      test_starvation();
      test_full_buffer();
      test_rd0();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Arbitrates the single register-file write port between the in-order pipeline writeback result and results from the multi-cycle multiply/divide unit (MDU). MDU results are buffered in a small FIFO and drained into free writeback slots. A starvation counter and a full-buffer override force drains. The block sits after the writeback select mux and drives the register file write port, stall back to the pipeline, and a pending-destination mask to the hazard unit.

## Interface
- XLEN, 32, data width
- REGW, 5, register index width
- DEPTH, 2, MDU result buffer entries (≥1)
- MAX_WAIT, 4, consecutive lost cycles before the buffer head is forced to win (≥1)

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- pipe_valid  in  1  pipeline writeback stage holds a result
- pipe_we  in  1  that result writes the register file
- pipe_rd  in  REGW  pipeline destination
- pipe_data  in  XLEN  pipeline write data (output of writeback mux)
- mdu_valid  in  1  MDU offers a result
- mdu_rd  in  REGW  MDU destination
- mdu_data  in  XLEN  MDU result
- mdu_ready  out  1  buffer accepts; transfer when mdu_valid && mdu_ready
- stall  out  1  pipeline writeback lost arbitration; hold stage, inputs stable
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  REGW  write address (registered)
- rf_wdata  out  XLEN  write data (registered)
- busy_mask  out  2^REGW  bit r set while an entry with rd=r sits in the buffer

## Operation
- Pipeline candidate: pipe_valid && pipe_we && pipe_rd≠0. Other pipeline results consume their cycle silently: no write, no stall.
- Buffer candidate: count>0; head entry only, FIFO order.
- Buffer wins iff count>0 and (pipeline candidate absent, or starve_cnt==MAX_WAIT, or count==DEPTH). Otherwise pipeline wins.
- stall = pipeline candidate && buffer wins. It is combinational from the inputs and registered state.
- Winner's rd/data are registered to rf_waddr/rf_wdata with rf_we=1. With no winner, rf_we=0, and waddr/wdata hold their previous values.
- Winning buffer pops its head.
- starve_cnt: cleared on a pop or when count==0. Otherwise it increments (saturating at MAX_WAIT) each cycle count>0 and the buffer loses.
- mdu_ready = count<DEPTH. It depends on registered state only. There is no pass-through into a full buffer even if it pops that cycle.
- Push on mdu_valid && mdu_ready, except mdu_rd=0: the handshake completes but nothing is stored.
- Simultaneous push and pop: count unchanged, order preserved. A pushed entry is never eligible in its push cycle.
- busy_mask: OR of one-hot rd over valid entries. A bit clears on the edge that pops the entry.
- Duplicate rd values in the buffer are legal and written in FIFO order.
- WAW/RAW against busy registers is the hazard unit's responsibility. The arbiter does not reorder or check.
- Reset (asynchronous, any time): buffer emptied, in-flight entries discarded, count=0, starve_cnt=0, rf_we=0, rf_waddr=0, rf_wdata=0. Combinationally, stall=0, mdu_ready=1, busy_mask=0.

## Timing
- Write latency: a pipeline result selected in cycle N is written at edge N+1, with rf_we high during cycle N+1.
- MDU: pushed at edge N, eligible in cycle N+1, earliest write at edge N+2.
- Throughput: one register-file write per cycle.
- Worst-case buffer wait under continuous pipeline writes: MAX_WAIT lost cycles, then a forced win. A full buffer wins every cycle until count<DEPTH.
- The pipeline is stalled at most one cycle per forced drain unless the buffer remains full.

## Test plan
- Reset asserted mid-traffic with 2 entries buffered → immediately rf_we=0, busy_mask=0, mdu_ready=1, stall=0; after release, no buffered write ever appears.
- pipe_valid=1, pipe_we=1, rd=5, data=0x00001234, MDU idle → next cycle rf_we=1, waddr=5, wdata=0x00001234, stall never high. Repeat with rd=0 → rf_we=0.
- Pipeline idle; MDU push rd=7 data=0xDEADBEEF at edge N → busy_mask[7]=1 in cycle N+1; write of 7/0xDEADBEEF at edge N+2; busy_mask[7]=0 afterwards.
- Pipeline writing rd=1,2,3,… every cycle; one MDU entry rd=9 → buffer loses 4 cycles; in the 5th cycle stall=1 and rd=9 is written; the stalled pipeline result is written the following cycle.
- Pipeline writing continuously; MDU pushes on two consecutive edges → count=2, mdu_ready=0, buffer wins immediately with stall=1; entries are written in push order; mdu_ready returns to 1 after the first pop.
- MDU result with rd=0 and mdu_valid=1 → handshake accepted, count unchanged, busy_mask unchanged, no write.
